// File: rtl/id_ex_pkg.sv
// rtl/id_ex_pkg.sv - shared widths, control bundles and payload type for the ID/EX stage
// Contents: width localparams, ex/mem/wb control structs, the packed ID/EX payload,
// the ID_EX_BUBBLE constant and a helper that zeroes the side-effecting controls.
package id_ex_pkg;

   localparam int DATA_WIDTH     = 64;
   localparam int REG_ID_WIDTH   = 5;
   localparam int EX_CTRL_WIDTH  = 19;
   localparam int MEM_CTRL_WIDTH = 3;
   localparam int WB_CTRL_WIDTH  = 2;

   typedef struct packed {
      logic       reg_to_pc;
      logic       alu_src;
      logic [6:0] alu_op;
      logic [2:0] func3;
      logic [6:0] func7;
   } ex_ctrl_t;

   typedef struct packed {
      logic branch;
      logic mem_read;
      logic mem_write;
   } mem_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]   pc;
      logic [DATA_WIDTH-1:0]   data1;
      logic [DATA_WIDTH-1:0]   data2;
      logic [DATA_WIDTH-1:0]   imm;
      logic [REG_ID_WIDTH-1:0] dest;
      logic [REG_ID_WIDTH-1:0] reg1;
      logic [REG_ID_WIDTH-1:0] reg2;
      ex_ctrl_t                ex;
      mem_ctrl_t               mem;
      wb_ctrl_t                wb;
   } id_ex_payload_t;

   localparam id_ex_payload_t ID_EX_BUBBLE = '0;

   // A squashed slot keeps its datapath bits but must never write memory or registers.
   function automatic id_ex_payload_t strip_ctrl(input id_ex_payload_t p);
      id_ex_payload_t r;
      r     = p;
      r.mem = '0;
      r.wb  = '0;
      return r;
   endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// rtl/pipe_skid_slot.sv - one ID/EX holding slot: valid bit plus payload register
// Ports:
//   clk, reset   clock, synchronous active-high reset (valid and payload to 0)
//   load_i       capture data_i and mark the slot valid
//   clear_i      mark the slot invalid and zero its mem/wb controls (wins over load_i)
//   data_i       payload to capture
//   valid_o      slot holds an instruction
//   data_o       registered payload; mem/wb controls are 0 whenever valid_o is 0
module pipe_skid_slot
   import id_ex_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           load_i,
   input  logic           clear_i,
   input  id_ex_payload_t data_i,
   output logic           valid_o,
   output id_ex_payload_t data_o
);

   logic           valid_q, valid_d;
   id_ex_payload_t data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear_i) begin
         valid_d = 1'b0;
         data_d  = strip_ctrl(data_q);
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= ID_EX_BUBBLE;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/id_ex_skid_regs.sv
// rtl/id_ex_skid_regs.sv - elastic ID/EX pipeline register with 2-entry skid buffer and flush
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   flush                      squash both slots next cycle, drop this cycle's input
//   in_valid / in_ready        decode handshake; in_ready is !skid_valid (flop output)
//   out_valid / out_ready      execute handshake; out_valid is the main slot's valid
//   *_in / *_out               pc, data1, data2, imm, dest, reg1, reg2, ex/mem/wb controls
// Optional (macro ID_EX_PERF_EN): perf_stall_cnt, perf_flush_cnt saturating counters.
module id_ex_skid_regs #(
   parameter int DATA_WIDTH     = id_ex_pkg::DATA_WIDTH,
   parameter int REG_ID_WIDTH   = id_ex_pkg::REG_ID_WIDTH,
   parameter int EX_CTRL_WIDTH  = id_ex_pkg::EX_CTRL_WIDTH,
   parameter int MEM_CTRL_WIDTH = id_ex_pkg::MEM_CTRL_WIDTH,
   parameter int WB_CTRL_WIDTH  = id_ex_pkg::WB_CTRL_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     pc_in,
   input  logic [DATA_WIDTH-1:0]     data1_in,
   input  logic [DATA_WIDTH-1:0]     data2_in,
   input  logic [DATA_WIDTH-1:0]     imm_in,
   input  logic [REG_ID_WIDTH-1:0]   dest_in,
   input  logic [REG_ID_WIDTH-1:0]   reg1_in,
   input  logic [REG_ID_WIDTH-1:0]   reg2_in,
   input  logic [EX_CTRL_WIDTH-1:0]  ex_control_in,
   input  logic [MEM_CTRL_WIDTH-1:0] mem_control_in,
   input  logic [WB_CTRL_WIDTH-1:0]  wb_control_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     pc_out,
   output logic [DATA_WIDTH-1:0]     data1_out,
   output logic [DATA_WIDTH-1:0]     data2_out,
   output logic [DATA_WIDTH-1:0]     imm_out,
   output logic [REG_ID_WIDTH-1:0]   dest_out,
   output logic [REG_ID_WIDTH-1:0]   reg1_out,
   output logic [REG_ID_WIDTH-1:0]   reg2_out,
   output logic [EX_CTRL_WIDTH-1:0]  ex_control_out,
   output logic [MEM_CTRL_WIDTH-1:0] mem_control_out,
   output logic [WB_CTRL_WIDTH-1:0]  wb_control_out
`ifdef ID_EX_PERF_EN
  ,output logic [31:0]               perf_stall_cnt,
   output logic [31:0]               perf_flush_cnt
`endif
);

   import id_ex_pkg::*;

   id_ex_payload_t in_pl, main_pl, skid_pl, main_src_pl;
   logic main_valid, skid_valid;
   logic accept, main_can_load, main_from_skid;
   logic main_load, main_clear, skid_load, skid_clear;

   assign in_pl = {pc_in, data1_in, data2_in, imm_in, dest_in, reg1_in, reg2_in,
                   ex_control_in, mem_control_in, wb_control_in};

   // in_ready depends only on skid state, so EX's out_ready never reaches ID combinationally.
   assign in_ready      = ~skid_valid;
   assign accept        = in_valid & in_ready;
   assign main_can_load = ~main_valid | out_ready;

   always_comb begin
      main_load      = 1'b0;
      main_clear     = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else if (main_can_load) begin
         if (skid_valid) begin
            // Skid is older than anything arriving now: it must move first.
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_load      = accept;
            skid_clear     = ~accept;
         end else if (accept) begin
            main_load = 1'b1;
         end else begin
            main_clear = 1'b1;
         end
      end else if (accept) begin
         skid_load = 1'b1;
      end
   end

   assign main_src_pl = main_from_skid ? skid_pl : in_pl;

   pipe_skid_slot u_main (
      .clk     (clk),
      .reset   (reset),
      .load_i  (main_load),
      .clear_i (main_clear),
      .data_i  (main_src_pl),
      .valid_o (main_valid),
      .data_o  (main_pl)
   );

   pipe_skid_slot u_skid (
      .clk     (clk),
      .reset   (reset),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .data_i  (in_pl),
      .valid_o (skid_valid),
      .data_o  (skid_pl)
   );

   assign out_valid = main_valid;
   assign {pc_out, data1_out, data2_out, imm_out, dest_out, reg1_out, reg2_out,
           ex_control_out, mem_control_out, wb_control_out} = main_pl;

`ifdef ID_EX_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (main_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_d = stall_cnt_q + 32'd1;
      if (flush && (main_valid || skid_valid) && flush_cnt_q != 32'hFFFF_FFFF)
         flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`else
   // Performance counters not built.
`endif

endmodule

// File: tb/tb_id_ex_skid_regs.sv
// tb/tb_id_ex_skid_regs.sv - randomized and directed bench for id_ex_skid_regs against a FIFO model
module tb_id_ex_skid_regs;
   import id_ex_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, flush, in_valid, in_ready, out_valid, out_ready;
   id_ex_payload_t cur, out_pl;
   logic [DATA_WIDTH-1:0]     pc_out, data1_out, data2_out, imm_out;
   logic [REG_ID_WIDTH-1:0]   dest_out, reg1_out, reg2_out;
   logic [EX_CTRL_WIDTH-1:0]  ex_control_out;
   logic [MEM_CTRL_WIDTH-1:0] mem_control_out;
   logic [WB_CTRL_WIDTH-1:0]  wb_control_out;
`ifdef ID_EX_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   id_ex_skid_regs dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .pc_in(cur.pc), .data1_in(cur.data1), .data2_in(cur.data2), .imm_in(cur.imm),
      .dest_in(cur.dest), .reg1_in(cur.reg1), .reg2_in(cur.reg2),
      .ex_control_in(cur.ex), .mem_control_in(cur.mem), .wb_control_in(cur.wb),
      .out_valid(out_valid), .out_ready(out_ready),
      .pc_out(pc_out), .data1_out(data1_out), .data2_out(data2_out), .imm_out(imm_out),
      .dest_out(dest_out), .reg1_out(reg1_out), .reg2_out(reg2_out),
      .ex_control_out(ex_control_out), .mem_control_out(mem_control_out),
      .wb_control_out(wb_control_out)
`ifdef ID_EX_PERF_EN
     ,.perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   assign out_pl = {pc_out, data1_out, data2_out, imm_out, dest_out, reg1_out, reg2_out,
                    ex_control_out, mem_control_out, wb_control_out};

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [319:0] got, input logic [319:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: the stage is a 2-deep FIFO; front is what execute sees.
   id_ex_payload_t mq[$];
   longint unsigned m_stall, m_flush;

   task automatic model_edge();
      int n;
      if (reset) begin
         mq.delete();
         m_stall = 0;
         m_flush = 0;
      end else begin
         n = mq.size();
         if (n > 0 && !out_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
         if (flush && n > 0 && m_flush < 64'hFFFF_FFFF) m_flush++;
         if (flush) mq.delete();
         else begin
            if (n > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && n < 2) mq.push_back(cur);
         end
      end
   endtask

   task automatic check_outputs();
      check_val("in_ready", 320'(in_ready), 320'(mq.size() < 2));
      check_val("out_valid", 320'(out_valid), 320'(mq.size() > 0));
      if (mq.size() > 0) check_val("payload", 320'(out_pl), 320'(mq[0]));
      else check_val("bubble_ctrl", 320'({mem_control_out, wb_control_out}), 320'(0));
`ifdef ID_EX_PERF_EN
      check_val("perf_stall", 320'(perf_stall_cnt), 320'(m_stall));
      check_val("perf_flush", 320'(perf_flush_cnt), 320'(m_flush));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   function automatic id_ex_payload_t rand_pl(input logic [63:0] pc);
      id_ex_payload_t p;
      p       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom};
      p.pc    = pc;
      return p;
   endfunction

   task automatic drive(input logic v, input logic [63:0] pc, input logic ordy, input logic fl);
      in_valid  = v;
      cur       = rand_pl(pc);
      out_ready = ordy;
      flush     = fl;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cur = '0;
      m_stall = 0; m_flush = 0;
      step();
      step();
      check_val("reset_payload", 320'(out_pl), 320'(0));
      check_val("reset_in_ready", 320'(in_ready), 320'(1));
      reset = 1'b0;

      // stream with out_ready held high
      drive(1, 64'h1000, 1, 0); step();
      check_val("stream_pc0", 320'(pc_out), 320'(64'h1000));
      drive(1, 64'h1004, 1, 0); step();
      check_val("stream_pc1", 320'(pc_out), 320'(64'h1004));
      drive(1, 64'h1008, 1, 0); step();
      check_val("stream_pc2", 320'(pc_out), 320'(64'h1008));
      check_val("stream_ready", 320'(in_ready), 320'(1));
      drive(0, 0, 1, 0); step();

      // back-pressure fills both slots
      drive(1, 64'h2000, 0, 0); step();
      drive(1, 64'h2004, 0, 0); step();
      check_val("bp_ready", 320'(in_ready), 320'(0));
      check_val("bp_hold", 320'(pc_out), 320'(64'h2000));
      drive(1, 64'h2FF0, 0, 0); step();
      check_val("bp_hold2", 320'(pc_out), 320'(64'h2000));
      drive(0, 0, 1, 0); step();
      check_val("bp_drain1", 320'(pc_out), 320'(64'h2004));
      check_val("bp_ready_back", 320'(in_ready), 320'(1));
      step();

      // flush with both slots full and input offered
      drive(1, 64'h2100, 0, 0); step();
      drive(1, 64'h2104, 0, 0); step();
      drive(1, 64'h2108, 0, 1); cur.wb = 2'b10; step();
      check_val("flush_valid", 320'(out_valid), 320'(0));
      check_val("flush_ctrl", 320'({mem_control_out, wb_control_out}), 320'(0));
      check_val("flush_ready", 320'(in_ready), 320'(1));
      drive(0, 0, 1, 0); step(); step();

      // drain while skid full and a new input waits
      drive(1, 64'h3000, 0, 0); step();
      drive(1, 64'h3004, 0, 0); step();
      drive(1, 64'h3008, 1, 0); step();
      check_val("skid_to_main", 320'(pc_out), 320'(64'h3004));
      step();
      check_val("after_skid", 320'(pc_out), 320'(64'h3008));
      drive(0, 0, 1, 0); step();

      // reset with both slots full
      drive(1, 64'h4000, 0, 0); step();
      drive(1, 64'h4004, 0, 0); step();
      drive(0, 0, 0, 0); reset = 1'b1; step();
      check_val("rst_full_payload", 320'(out_pl), 320'(0));
      check_val("rst_full_valid", 320'(out_valid), 320'(0));
      check_val("rst_full_ready", 320'(in_ready), 320'(1));
      reset = 1'b0;

`ifdef ID_EX_PERF_EN
      drive(1, 64'h5000, 0, 0); step();
      drive(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step();
      drive(0, 0, 1, 1); step();
      check_val("perf_stall5", 320'(perf_stall_cnt), 320'(5));
      check_val("perf_flush1", 320'(perf_flush_cnt), 320'(1));
      drive(0, 0, 1, 0); step();
`endif

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
         reset = 1'($urandom_range(0, 99) == 0);
         step();
      end
      reset = 1'b0;
      drive(0, 0, 1, 0); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
